// File: rtl/kmeans_point_labeler.sv
// kmeans_point_labeler: captures 4 centroids, labels (x,y) points by nearest Manhattan centroid, keeps a hit histogram
// Ports: clk/rst (async, active-high); i_cent_valid/i_cent_data centroid beats {x,y};
//   i_pt_valid/i_pt_data/o_pt_ready point input; o_lbl_valid/i_lbl_ready/o_lbl_idx/o_lbl_dist/o_lbl_point label output;
//   o_frame_done pulse after DATA_SIZE-th label accepted; i_cnt_sel/o_cnt_out histogram read
module kmeans_point_labeler #(
  parameter int DATA_SIZE = 4096,
  parameter int CNT_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cent_valid,
  input  logic [15:0]      i_cent_data,
  input  logic             i_pt_valid,
  input  logic [15:0]      i_pt_data,
  output logic             o_pt_ready,
  output logic             o_lbl_valid,
  input  logic             i_lbl_ready,
  output logic [1:0]       o_lbl_idx,
  output logic [8:0]       o_lbl_dist,
  output logic [15:0]      o_lbl_point,
  output logic             o_frame_done,
  input  logic [1:0]       i_cnt_sel,
  output logic [CNT_W-1:0] o_cnt_out
);
  localparam int PW = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1;
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
  state_t           r_state, w_next;
  logic [15:0]      r_cent [4];
  logic [1:0]       r_beat;
  logic [CNT_W-1:0] r_hist [4];
  logic [PW-1:0]    r_pcnt;
  logic [8:0]       w_d [4];
  logic [8:0]       w_min;
  logic [1:0]       w_idx;
  logic             w_acc, w_take, w_reload, w_last;
  function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
    return a > b ? a - b : b - a;
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_dist
    assign w_d[i] = 9'(absd(i_pt_data[15:8], r_cent[i][15:8])) + 9'(absd(i_pt_data[7:0], r_cent[i][7:0]));
  end
  // strict less-than scanned upward so ties resolve to the lowest index
  always_comb begin
    w_min = w_d[0];
    w_idx = 2'd0;
    for (int k = 1; k < 4; k++) begin
      w_idx = w_d[k] < w_min ? 2'(k) : w_idx;
      w_min = w_d[k] < w_min ? w_d[k] : w_min;
    end
  end
  // r_beat is 0 in EMPTY and RUN, so the first beat of any load lands in centroid 0
  always_comb begin
    w_next = r_state;
    w_next = i_cent_valid ? (r_beat == 2'd3 ? RUN : LOAD) : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= EMPTY;
    else r_state <= w_next;
  assign o_pt_ready = (r_state == RUN) & (~o_lbl_valid | i_lbl_ready);
  assign w_acc      = i_pt_valid & o_pt_ready;
  assign w_take     = o_lbl_valid & i_lbl_ready;
  assign w_reload   = i_cent_valid & (r_state == RUN);
  assign w_last     = r_pcnt == PW'(DATA_SIZE - 1);
  assign o_cnt_out  = r_hist[i_cnt_sel];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cent       <= '{default: '0};
      r_beat       <= '0;
      r_hist       <= '{default: '0};
      r_pcnt       <= '0;
      o_lbl_valid  <= 1'b0;
      o_lbl_idx    <= '0;
      o_lbl_dist   <= '0;
      o_lbl_point  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      if (i_cent_valid) begin
        r_cent[r_beat] <= i_cent_data;
        r_beat         <= r_beat + 2'd1;
      end
      o_lbl_valid <= w_acc | (o_lbl_valid & ~i_lbl_ready);
      if (w_acc) begin
        o_lbl_idx   <= w_idx;
        o_lbl_dist  <= w_min;
        o_lbl_point <= i_pt_data;
      end
      o_frame_done <= w_take & w_last & ~w_reload;
      // a reload clear overrides a same-cycle histogram increment or point count
      if (w_reload) begin
        r_hist <= '{default: '0};
        r_pcnt <= '0;
      end else begin
        if (w_acc && !(&r_hist[w_idx])) r_hist[w_idx] <= r_hist[w_idx] + CNT_W'(1);
        if (w_take) r_pcnt <= w_last ? '0 : r_pcnt + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_kmeans_point_labeler.sv
// tb_kmeans_point_labeler: directed self-checking bench for kmeans_point_labeler with DATA_SIZE=8
module tb_kmeans_point_labeler;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_cent_valid = 1'b0, i_pt_valid = 1'b0, i_lbl_ready = 1'b0;
  logic [15:0] i_cent_data = '0, i_pt_data = '0;
  logic [1:0]  i_cnt_sel = '0;
  logic        o_pt_ready, o_lbl_valid, o_frame_done;
  logic [1:0]  o_lbl_idx;
  logic [8:0]  o_lbl_dist;
  logic [15:0] o_lbl_point;
  logic [12:0] o_cnt_out;
  int          errors = 0, checks = 0, pcnt = 0, fd_seen = 0, sent = 0;
  logic        fd_exp = 1'b0, mrun = 1'b0;
  logic [1:0]  mb = '0;
  logic [15:0] mc [4];
  logic [26:0] sb [$];
  kmeans_point_labeler #(.DATA_SIZE(8), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .i_cent_valid(i_cent_valid), .i_cent_data(i_cent_data),
    .i_pt_valid(i_pt_valid), .i_pt_data(i_pt_data), .o_pt_ready(o_pt_ready),
    .o_lbl_valid(o_lbl_valid), .i_lbl_ready(i_lbl_ready), .o_lbl_idx(o_lbl_idx),
    .o_lbl_dist(o_lbl_dist), .o_lbl_point(o_lbl_point), .o_frame_done(o_frame_done),
    .i_cnt_sel(i_cnt_sel), .o_cnt_out(o_cnt_out)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] model(input logic [15:0] p);
    int best = 1 << 20;
    int dx, dy;
    logic [1:0] bi = '0;
    for (int k = 3; k >= 0; k--) begin
      dx = int'(p[15:8]) - int'(mc[k][15:8]);
      dy = int'(p[7:0]) - int'(mc[k][7:0]);
      dx = dx < 0 ? -dx : dx;
      dy = dy < 0 ? -dy : dy;
      if (dx + dy <= best) begin
        best = dx + dy;
        bi = 2'(k);
      end
    end
    return {bi, 9'(best)};
  endfunction
  task automatic step(input logic pv, input logic [15:0] pd, input logic lr, input logic cv, input logic [15:0] cd);
    logic [26:0] e;
    logic acc;
    i_pt_valid = pv; i_pt_data = pd; i_lbl_ready = lr; i_cent_valid = cv; i_cent_data = cd;
    #1;
    chk("frame_done", o_frame_done, fd_exp);
    if (o_frame_done) fd_seen++;
    chk("lbl_valid", o_lbl_valid, sb.size() != 0);
    chk("pt_ready", o_pt_ready, mrun && (sb.size() == 0 || lr));
    acc = pv && mrun && (sb.size() == 0 || lr);
    fd_exp = 1'b0;
    if (sb.size() != 0 && lr) begin
      e = sb.pop_front();
      chk("label", {o_lbl_point, o_lbl_idx, o_lbl_dist}, e);
      pcnt = (pcnt + 1) % 8;
      fd_exp = pcnt == 0;
    end
    if (acc) begin
      sb.push_back({pd, model(pd)});
      sent++;
    end
    if (cv) begin
      if (mrun) begin
        pcnt = 0;
        fd_exp = 1'b0;
        mrun = 1'b0;
      end
      mc[mb] = cd;
      mb = mb + 2'd1;
      if (mb == 2'd0) mrun = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic chk_hist(input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int s = 0; s < 4; s++) begin
      i_cnt_sel = 2'(s);
      #1;
      chk($sformatf("cnt%0d", s), o_cnt_out, e[s]);
    end
  endtask
  initial begin
    logic [15:0] pts [6];
    int eidx [6], edist [6];
    int s0;
    pts   = '{16'h1212, 16'h8E92, 16'h1050, 16'h5050, 16'h9012, 16'h128E};
    eidx  = '{0, 3, 0, 0, 2, 1};
    edist = '{4, 4, 64, 128, 2, 4};
    mc = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_pt_ready", o_pt_ready, 0);
    chk("rst_lbl_valid", o_lbl_valid, 0);
    chk("rst_lbl_idx", o_lbl_idx, 0);
    chk("rst_lbl_dist", o_lbl_dist, 0);
    chk("rst_lbl_point", o_lbl_point, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_cnt_out", o_cnt_out, 0);
    rst = 1'b0;
    step(0, 0, 1, 1, 16'h1010);
    step(0, 0, 1, 1, 16'h1090);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 16'h9010);
    step(0, 0, 1, 1, 16'h9090);
    for (int i = 0; i < 6; i++) begin
      step(1, pts[i], 1, 0, 0);
      chk($sformatf("idx_%h", pts[i]), o_lbl_idx, eidx[i]);
      chk($sformatf("dist_%h", pts[i]), o_lbl_dist, edist[i]);
    end
    step(0, 0, 1, 0, 0);
    chk_hist(3, 1, 1, 1);
    step(1, 16'h2020, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 16'h3030, 0, 0, 0);
      chk("hold_point", o_lbl_point, 16'h2020);
      chk("hold_dist", o_lbl_dist, 32);
    end
    step(1, 16'h3030, 1, 0, 0);
    step(1, 16'h8080, 1, 0, 0);
    step(1, 16'h1188, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("bp_drained", sb.size(), 0);
    for (int k = 0; k < 10; k++) step(1, {8'(k * 23), 8'(200 - k * 17)}, 1, 0, 0);
    for (int b = 0; b < 4; b++) step(1, 16'h4040 + 16'(b), 1, 1, 16'hFFFF);
    chk_hist(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, {8'(k * 40), 8'(k * 7)}, 1, 0, 0);
      chk("idx_after_reload", o_lbl_idx, 0);
    end
    step(0, 0, 1, 0, 0);
    chk_hist(5, 0, 0, 0);
    step(0, 0, 1, 1, 16'h1010);
    step(0, 0, 1, 1, 16'h1090);
    step(0, 0, 1, 1, 16'h9010);
    step(0, 0, 1, 1, 16'h9090);
    fd_seen = 0;
    s0 = sent;
    for (int t = 0; t < 400 && sent - s0 < 16; t++)
      step(1, 16'h1111 + 16'(sent - s0), 1'($urandom_range(0, 1)), 0, 0);
    for (int t = 0; t < 20 && sb.size() != 0; t++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("frame_sent", sent - s0, 16);
    chk("frame_pulses", fd_seen, 2);
    step(1, 16'h1515, 0, 0, 0);
    i_cnt_sel = 2'd0;
    #1;
    chk("pre_rst_cnt", o_cnt_out, 17);
    rst = 1'b1;
    #1;
    chk("arst_lbl_valid", o_lbl_valid, 0);
    chk("arst_pt_ready", o_pt_ready, 0);
    chk("arst_cnt_out", o_cnt_out, 0);
    chk("arst_lbl_point", o_lbl_point, 0);
    sb.delete();
    mrun = 1'b0; mb = '0; pcnt = 0; fd_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 16'h1515, 1, 0, 0);
    step(1, 16'h1515, 1, 1, 16'h1010);
    step(1, 16'h1515, 1, 1, 16'h1090);
    step(1, 16'h1515, 1, 1, 16'h9010);
    step(1, 16'h1515, 1, 1, 16'h9090);
    step(1, 16'h8E92, 1, 0, 0);
    chk("post_rst_idx", o_lbl_idx, 3);
    chk("post_rst_dist", o_lbl_dist, 4);
    step(0, 0, 1, 0, 0);
    chk_hist(0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
